// File: rtl/id_issue_queue_pkg.sv
// rtl/id_issue_queue_pkg.sv - shared register-address width, bubble values and load-use compare
package id_issue_queue_pkg;

    localparam int REG_ADDR_W = 5;

    // A bubble toward EX is all zero: no register fields, not a load, zero payload.
    localparam logic [REG_ADDR_W-1:0] REG_BUBBLE  = '0;
    localparam logic                  LOAD_BUBBLE = 1'b0;

    // True when an in-flight load writes a register that one of the given sources reads.
    // Register 0 never carries a dependency.
    function automatic logic load_use_hit(
        input logic                  ld_valid,
        input logic [REG_ADDR_W-1:0] ld_rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return ld_valid && (ld_rd != '0) &&
               (((ld_rd == rs1) && (rs1 != '0)) || ((ld_rd == rs2) && (rs2 != '0)));
    endfunction

endpackage

// File: rtl/id_issue_queue_fifo_mem.sv
// rtl/id_issue_queue_fifo_mem.sv - circular entry store with read/write pointers and occupancy count
module id_issue_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 80,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty,
    output logic              o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; clear drops entries but keeps stale data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_wr_en) begin
                mem[wr_ptr] <= i_wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

    assign o_rd_data = mem[rd_ptr];
    assign o_empty   = (o_count == '0);
    assign o_full    = (o_count == CNT_W'(DEPTH));

endmodule

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - decode-to-EX issue FIFO with load-use bubbles and flush; optional ID_ISSUE_QUEUE_BYPASS_EN
module id_issue_queue
    import id_issue_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PAYLOAD_W-1:0]  i_payload,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_is_load,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PAYLOAD_W-1:0]  o_payload,
    output logic [REG_ADDR_W-1:0] o_rs1,
    output logic [REG_ADDR_W-1:0] o_rs2,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_is_load,
    input  logic                  i_ex_load_valid,
    input  logic [REG_ADDR_W-1:0] i_ex_load_rd,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_hazard
);

    localparam int ENTRY_W = PAYLOAD_W + 3 * REG_ADDR_W + 1;

    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic [PAYLOAD_W-1:0]  head_payload;
    logic [REG_ADDR_W-1:0] head_rs1;
    logic [REG_ADDR_W-1:0] head_rs2;
    logic [REG_ADDR_W-1:0] head_rd;
    logic                  head_is_load;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  head_present;
    logic                  bypass_ok;
    logic                  issue;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_entry = {i_payload, i_rs1, i_rs2, i_rd, i_is_load};
    assign {head_payload, head_rs1, head_rs2, head_rd, head_is_load} = head_entry;
    assign head_present = ~fifo_empty;

    // o_ready depends only on stored occupancy, never on i_ready.
    assign o_ready = ~fifo_full;

    // Hazard, bypass and issue decisions plus the bubble mux toward EX.
    always_comb begin
        o_hazard = head_present & load_use_hit(i_ex_load_valid, i_ex_load_rd, head_rs1, head_rs2);
`ifdef ID_ISSUE_QUEUE_BYPASS_EN
        bypass_ok = fifo_empty & i_valid &
                    ~load_use_hit(i_ex_load_valid, i_ex_load_rd, i_rs1, i_rs2);
`else
        bypass_ok = 1'b0;
`endif
        issue     = ~i_flush & ((head_present & ~o_hazard) | bypass_ok);
        o_valid   = issue;
        o_payload = '0;
        o_rs1     = REG_BUBBLE;
        o_rs2     = REG_BUBBLE;
        o_rd      = REG_BUBBLE;
        o_is_load = LOAD_BUBBLE;
        if (issue && bypass_ok) begin
            o_payload = i_payload;
            o_rs1     = i_rs1;
            o_rs2     = i_rs2;
            o_rd      = i_rd;
            o_is_load = i_is_load;
        end else if (issue) begin
            o_payload = head_payload;
            o_rs1     = head_rs1;
            o_rs2     = head_rs2;
            o_rd      = head_rd;
            o_is_load = head_is_load;
        end
    end

    // A bypassed bundle that EX takes immediately is never stored; flush drops any push.
    assign wr_en = i_valid & o_ready & ~i_flush & ~(bypass_ok & i_ready);
    assign rd_en = issue & i_ready & head_present;

    id_issue_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W),
        .CNT_W  (CNT_W)
    ) u_fifo_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (i_flush),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_entry),
        .i_rd_en   (rd_en),
        .o_rd_data (head_entry),
        .o_count   (o_count),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full)
    );

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
Parametrised replacement for the single-entry decode-to-execute pipeline register. Buffers up to DEPTH decoded instruction bundles in a FIFO between the decoder and EX, using valid/ready handshakes on both sides. Detects load-use hazards at the queue head and inserts all-zero bubbles toward EX. Supports a synchronous flush for branches and jumps.

Parameters:
- DEPTH, 4, number of bundle entries; power of 2, minimum 2.
- PAYLOAD_W, 64, width of the opaque decode bundle (decode info, imm, csr addr, pc slice).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous flush; discard all entries.
- i_valid  in  1  decoder presents a bundle.
- o_ready  out  1  queue accepts a bundle.
- i_payload  in  PAYLOAD_W  decoded bundle.
- i_rs1  in  5  source register 1; 0 = unused.
- i_rs2  in  5  source register 2; 0 = unused.
- i_rd  in  5  destination register.
- i_is_load  in  1  bundle is a load.
- o_valid  out  1  head bundle issuable to EX.
- i_ready  in  1  EX accepts the head bundle.
- o_payload  out  PAYLOAD_W  head bundle.
- o_rs1  out  5  head source register 1.
- o_rs2  out  5  head source register 2.
- o_rd  out  5  head destination register.
- o_is_load  out  1  head is a load.
- i_ex_load_valid  in  1  EX currently holds an unfinished load.
- i_ex_load_rd  in  5  destination register of that load.
- o_count  out  CNT_W  current occupancy.
- o_hazard  out  1  load-use stall active at head.

Behaviour:
- Storage: DEPTH-entry circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. o_count is a registered counter.
- Reset: pointers, count and all storage cleared. After reset o_valid=0, o_hazard=0, o_ready=1, o_count=0, and all data outputs are 0.
- push = i_valid & o_ready. pop = o_valid & i_ready.
- o_ready = (o_count != DEPTH). It is registered-state-derived only; there is no combinational path from i_ready. A push into a full queue is therefore impossible, even if a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Latency, bypass off: a bundle pushed in cycle N is visible at the head in cycle N+1 when the queue was empty. Ordering is strict FIFO.
- Hazard: o_hazard = head_present & i_ex_load_valid & (i_ex_load_rd != 0) & ((i_ex_load_rd == head_rs1 & head_rs1 != 0) | (i_ex_load_rd == head_rs2 & head_rs2 != 0)).
- o_valid = head_present & ~o_hazard.
- Bubble rule: whenever o_valid=0, o_payload, o_rs1, o_rs2, o_rd and o_is_load are driven to 0. Otherwise they show the head entry and stay stable until popped.
- Flush: when i_flush=1, pointers and count are cleared at the next edge. A push in the same cycle is dropped, and any pop is irrelevant. During the flush cycle o_valid and the data outputs are forced to 0 combinationally. o_ready is 1 in the cycle after the flush.
- Reset asserted mid-operation clears everything immediately (asynchronous) and drops in-flight entries.
- Payload is opaque. No arithmetic is performed on it.

Optional Feature:
- Macro ID_ISSUE_QUEUE_BYPASS_EN.
- Defined: when the queue is empty, i_valid=1 and the input's own rs1/rs2 raise no hazard against i_ex_load_rd, the input fields drive the outputs combinationally and o_valid=1.
  - If i_ready=1, the bundle is consumed without being written; latency is 0.
  - If i_ready=0, the bundle is written normally.
  - Flush still overrides.
- Undefined: no bypass; minimum latency is 1 cycle.

Decomposition:
- Shared package/defines file holds REG_ADDR_W=5, the bubble value (all zero), and the hazard-compare function.
- One natural sub-module, id_issue_fifo_mem: the storage array with its pointers and count. id_issue_queue wraps it with the hazard, bubble, flush and bypass logic.

Test Plan:
- Fill and drain: push 4 bundles (payload 0x1..0x4) with i_ready=0. Then o_count=4, o_ready=0, and the head is 0x1. Raise i_ready: 0x1..0x4 issue in order, one per cycle, ending with o_count=0 and o_valid=0.
- Wrap-around: run 10 push/pop pairs per cycle, keeping occupancy at 1 or 2. Output order must equal input order and o_count must never exceed 2.
- Load-use: head has rs1=5 while i_ex_load_valid=1 and i_ex_load_rd=5. Expect o_hazard=1, o_valid=0 and all outputs 0. Drop i_ex_load_valid and the head issues the next cycle. With i_ex_load_rd=0 there must be no hazard.
- Flush: with 3 entries queued and i_valid=1 in the flush cycle, expect o_count=0 and o_ready=1 next cycle, and the pushed bundle is not present.
- Asynchronous reset mid-stream: assert i_rst_n=0 between clock edges with 2 entries queued. Outputs go to 0 immediately and o_count=0.
- Bypass (macro defined): empty queue, i_valid=1, i_ready=1, payload 0xAB. o_valid=1 and o_payload=0xAB in the same cycle, and o_count stays 0.
